mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0500_0000: 32-byte register window base, aligned to 32 bytes.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port mem_valid, input, 1: bus request valid; held until mem_ready.
REQ-005 SHALL have port mem_addr, input, 32: byte address of request.
REQ-006 SHALL have port mem_wdata, input, 32: write data.
REQ-007 SHALL have port mem_wstrb, input, 4: byte write strobes; 4'b0000 means read.
REQ-008 SHALL have port mem_ready, output, 1: one-cycle completion pulse for a selected request.
REQ-009 SHALL have port mem_rdata, output, 32: read data, valid while mem_ready=1, else 0.
REQ-010 SHALL have port irq_out, output, 1: level interrupt to the CPU irq vector.

Function
REQ-011 SHALL decode sel = mem_valid && mem_addr[31:5]==BASE_ADDR[31:5]; mem_addr[1:0] ignored.
REQ-012 SHALL register mem_ready <= sel && !mem_ready: one wait state; pulse exactly one cycle; back-to-back requests complete every second cycle.
REQ-013 SHALL apply a write, and capture mem_rdata, on the edge that sets mem_ready, so each request takes effect exactly once.
REQ-014 SHALL honour byte strobes on every writable register; bits beyond a register's width read 0.
REQ-015 SHALL implement offset 0x00 CTRL (R/W): bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable).
REQ-016 SHALL implement offset 0x04 LOAD (R/W, 32 bits): reload value.
REQ-017 SHALL implement offset 0x08 COUNT (R/W, 32 bits): current count; writing it also clears the prescaler.
REQ-018 SHALL implement offset 0x0C STATUS: bit0 EXP; read returns EXP; writing 1 to bit0 clears it; writing 0 has no effect.
REQ-019 SHALL implement offset 0x10 PRESC (R/W, 16 bits): prescale divisor minus one.
REQ-020 SHALL complete accesses to offsets 0x14-0x1C normally: reads return 0, writes are ignored.
REQ-021 SHALL run a 16-bit prescaler while EN=1; it counts 0..PRESC, then wraps to 0 and emits a one-cycle tick.
REQ-022 SHALL hold the prescaler at 0 while EN=0; an EN 0->1 write restarts it from 0.
REQ-023 SHALL, on tick with COUNT!=0, decrement COUNT by 1.
REQ-024 SHALL, on tick with COUNT==0: set EXP; if AUTO=1, COUNT<=LOAD and EN stays 1; if AUTO=0, COUNT stays 0 and EN<=0.
REQ-025 SHALL give an expiry period of (LOAD+1)*(PRESC+1) clk cycles in auto-reload mode.
REQ-026 SHALL, when a COUNT write coincides with a tick, apply the bus write and discard the tick.
REQ-027 SHALL, when a CTRL write coincides with a tick, apply the written CTRL value; the tick's COUNT/EXP effects still occur, except that EN takes the written value.
REQ-028 SHALL, when an EXP set coincides with a STATUS clear write, leave EXP=1 (set wins).
REQ-029 SHALL drive irq_out = EXP && IE from registers, with no combinational path from bus inputs.
REQ-030 SHALL not change LOAD or PRESC on expiry.

Reset
REQ-031 SHALL, on reset asserted at any time, immediately force CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESC=0, prescaler=0, mem_ready=0, mem_rdata=0, irq_out=0.
REQ-032 SHALL abandon an in-flight bus request on reset; a request still valid after deassertion is serviced afresh per REQ-012.

Verification
REQ-033 SHALL pass: read of BASE+0x04 after reset -> mem_ready high exactly in cycle 2 of request, mem_rdata=0, single pulse.
REQ-034 SHALL pass: PRESC=3, LOAD=4, COUNT=4, CTRL=0x7 -> EXP and irq_out rise 20 cycles after the CTRL write edge, and every 20 cycles thereafter after each W1C to STATUS.
REQ-035 SHALL pass: one-shot with CTRL=0x5, COUNT=2, PRESC=0 -> EXP set after 3 cycles, EN reads 0, COUNT stays 0, no further events.
REQ-036 SHALL pass: STATUS write 0x1 in the same cycle as expiry -> EXP remains 1, and irq_out remains 1.
REQ-037 SHALL pass: write LOAD with mem_wstrb=4'b0010, data 32'hAABBCCDD onto LOAD=0 -> LOAD reads 32'h0000CC00.
REQ-038 SHALL pass: reset pulsed mid-count with a pending read -> all outputs 0 within the reset cycle, no mem_ready during reset.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with prescaler, auto-reload and a level irq.
// Ports: clk, reset (async high), mem_valid/addr/wdata/wstrb/ready/rdata bus, irq_out.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0500_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq_out
);

  logic        en, auto_rl, ie, exp_flag;
  logic [31:0] load, count;
  logic [15:0] presc, pcnt;

  logic        en_n, auto_n, ie_n, exp_n;
  logic [31:0] load_n, count_n;
  logic [15:0] presc_n, pcnt_n;
  logic [31:0] presc_m;
  logic [31:0] rdata_n;

  logic        sel, acc, wr, rd;
  logic [2:0]  off;
  logic        ctrl_wr, load_wr, count_wr;
  logic        presc_wr, clr;
  logic        tick, tick_eff, expire;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

  assign sel = mem_valid &&
               (mem_addr[31:5] == BASE_ADDR[31:5]);
  // A request is serviced only on the edge that raises mem_ready.
  assign acc = sel && !mem_ready;
  assign wr  = acc && (mem_wstrb != 4'b0000);
  assign rd  = acc && (mem_wstrb == 4'b0000);
  assign off = mem_addr[4:2];

  assign ctrl_wr  = wr && (off == 3'd0) && mem_wstrb[0];
  assign load_wr  = wr && (off == 3'd1);
  assign count_wr = wr && (off == 3'd2);
  assign presc_wr = wr && (off == 3'd4);
  assign clr      = wr && (off == 3'd3) &&
                    mem_wstrb[0] && mem_wdata[0];

  assign tick     = en && (pcnt == presc);
  // A bus write to COUNT swallows a coincident tick.
  assign tick_eff = tick && !count_wr;
  assign expire   = tick_eff && (count == 32'd0);

  assign presc_m = merge({16'd0, presc}, mem_wdata, mem_wstrb);

  always_comb begin
    en_n    = en;
    auto_n  = auto_rl;
    ie_n    = ie;
    exp_n   = exp_flag;
    load_n  = load;
    count_n = count;
    presc_n = presc;
    pcnt_n  = pcnt;

    if (tick_eff) begin
      if (count != 32'd0)
        count_n = count - 32'd1;
      else if (auto_rl)
        count_n = load;
      else
        en_n = 1'b0;
    end

    // Set beats clear when both land together.
    if (clr)
      exp_n = 1'b0;
    if (expire)
      exp_n = 1'b1;

    if (ctrl_wr) begin
      en_n   = mem_wdata[0];
      auto_n = mem_wdata[1];
      ie_n   = mem_wdata[2];
    end
    if (load_wr)
      load_n = merge(load, mem_wdata, mem_wstrb);
    if (count_wr)
      count_n = merge(count, mem_wdata, mem_wstrb);
    if (presc_wr)
      presc_n = presc_m[15:0];

    // Prescaler sits at 0 whenever the timer is (or is becoming)
    // disabled, so an enable always starts a fresh period.
    if (!en_n || !en || count_wr || tick)
      pcnt_n = 16'd0;
    else
      pcnt_n = pcnt + 16'd1;
  end

  always_comb begin
    rdata_n = 32'd0;
    if (rd) begin
      case (off)
        3'd0:    rdata_n = {29'd0, ie, auto_rl, en};
        3'd1:    rdata_n = load;
        3'd2:    rdata_n = count;
        3'd3:    rdata_n = {31'd0, exp_flag};
        3'd4:    rdata_n = {16'd0, presc};
        default: rdata_n = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en        <= 1'b0;
      auto_rl   <= 1'b0;
      ie        <= 1'b0;
      exp_flag  <= 1'b0;
      load      <= 32'd0;
      count     <= 32'd0;
      presc     <= 16'd0;
      pcnt      <= 16'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      en        <= en_n;
      auto_rl   <= auto_n;
      ie        <= ie_n;
      exp_flag  <= exp_n;
      load      <= load_n;
      count     <= count_n;
      presc     <= presc_n;
      pcnt      <= pcnt_n;
      mem_ready <= acc;
      mem_rdata <= rdata_n;
    end
  end

  assign irq_out = exp_flag && ie;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scenario-task bench for mmio_timer.
// Expected read data is queued at issue and popped on mem_ready.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0500_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq_out;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic [31:0] sb[$];

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic bus(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [31:0] r,
    output int          n
  );
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_ready && n < 16);
    r = mem_rdata;
    if (!mem_ready) begin
      checks++;
      failures++;
      $display("FAIL bus_timeout addr=%h", a);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0;
  endtask

  task automatic wr(input logic [4:0] o,
                    input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] r;
    int n;
    bus(BASE + {27'd0, o}, d, s, r, n);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!irq_out && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] r, e;
    int n;
    reset = 1'b1;
    mem_valid = 1'b0;
    mem_addr = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    #1;
    checks++;
    if ({mem_ready, mem_rdata, irq_out} !== 34'd0) begin
      failures++;
      $display("FAIL reset_outs got=%h want=0",
               {mem_ready, mem_rdata, irq_out});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(32'd0);
    bus(BASE + 32'h4, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL load_rst got=%h want=%h", r, e);
    end
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL ready_lat got=%0d want=1", n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_pulse got=%b want=0", mem_ready);
    end
  endtask

  task automatic test_strobe;
    logic [31:0] r, e;
    int n;
    wr(5'h04, 32'hAABBCCDD, 4'b0010);
    sb.push_back(32'h0000CC00);
    bus(BASE + 32'h4, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL load_b1 got=%h want=%h", r, e);
    end
    wr(5'h04, 32'h11223344, 4'b1001);
    sb.push_back(32'h1100CC44);
    // Low address bits must be ignored.
    bus(BASE + 32'h6, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL load_b03 got=%h want=%h", r, e);
    end
    wr(5'h10, 32'hFFFFFFFF, 4'b1111);
    sb.push_back(32'h0000FFFF);
    bus(BASE + 32'h10, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL presc_w got=%h want=%h", r, e);
    end
    wr(5'h00, 32'hFFFFFFFE, 4'b1111);
    sb.push_back(32'h00000006);
    bus(BASE + 32'h0, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL ctrl_w got=%h want=%h", r, e);
    end
    wr(5'h00, 32'd0, 4'b1111);
    wr(5'h10, 32'd0, 4'b1111);
  endtask

  task automatic test_unmapped;
    logic [31:0] r, e;
    int n, p;
    wr(5'h14, 32'hDEADBEEF, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'd0);
      bus(BASE + 32'h14 + 32'(4 * i), 32'd0, 4'd0, r, n);
      e = sb.pop_front();
      checks++;
      if (r !== e) begin
        failures++;
        $display("FAIL unmapped%0d got=%h want=%h", i, r, e);
      end
    end
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr = BASE + 32'h20;
    mem_wstrb = 4'd0;
    p = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (mem_ready) p++;
    end
    mem_valid = 1'b0;
    checks++;
    if (p !== 0) begin
      failures++;
      $display("FAIL out_of_win got=%0d want=0", p);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    int p;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr = BASE + 32'h4;
    mem_wstrb = 4'd0;
    repeat (3) sb.push_back(32'h1100CC44);
    p = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (mem_ready !== 1'(k % 2)) begin
        failures++;
        $display("FAIL b2b_rdy%0d got=%b want=%b",
                 k, mem_ready, 1'(k % 2));
      end
      if (mem_ready) begin
        p++;
        e = sb.pop_front();
        checks++;
        if (mem_rdata !== e) begin
          failures++;
          $display("FAIL b2b_data got=%h want=%h", mem_rdata, e);
        end
      end
    end
    mem_valid = 1'b0;
    checks++;
    if (p !== 3 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=3", p);
    end
  endtask

  task automatic test_auto_reload;
    logic [31:0] r, e;
    int n;
    int unsigned t;
    wr(5'h10, 32'd3, 4'hF);
    wr(5'h04, 32'd4, 4'hF);
    wr(5'h08, 32'd4, 4'hF);
    wr(5'h0C, 32'd1, 4'hF);
    wr(5'h00, 32'd7, 4'hF);
    wait_irq(n);
    t = cyc;
    checks++;
    if (n !== 20) begin
      failures++;
      $display("FAIL auto_first got=%0d want=20", n);
    end
    for (int i = 0; i < 2; i++) begin
      wr(5'h0C, 32'd1, 4'hF);
      checks++;
      if (irq_out !== 1'b0) begin
        failures++;
        $display("FAIL auto_w1c%0d got=%b want=0", i, irq_out);
      end
      wait_irq(n);
      checks++;
      if (cyc - t !== 20) begin
        failures++;
        $display("FAIL auto_per%0d got=%0d want=20", i, cyc - t);
      end
      t = cyc;
    end
    wr(5'h00, 32'd0, 4'hF);
    wr(5'h0C, 32'd1, 4'hF);
    sb.push_back(32'd4);
    bus(BASE + 32'h4, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL load_kept got=%h want=%h", r, e);
    end
    sb.push_back(32'd3);
    bus(BASE + 32'h10, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL presc_kept got=%h want=%h", r, e);
    end
  endtask

  task automatic test_one_shot;
    logic [31:0] r, e;
    int n, p;
    wr(5'h10, 32'd0, 4'hF);
    wr(5'h08, 32'd2, 4'hF);
    wr(5'h00, 32'd5, 4'hF);
    wait_irq(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL oneshot_lat got=%0d want=3", n);
    end
    sb.push_back(32'd4);
    bus(BASE + 32'h0, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL oneshot_ctrl got=%h want=%h", r, e);
    end
    sb.push_back(32'd1);
    bus(BASE + 32'hC, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL oneshot_exp got=%h want=%h", r, e);
    end
    wr(5'h0C, 32'd1, 4'hF);
    p = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (irq_out) p++;
    end
    checks++;
    if (p !== 0) begin
      failures++;
      $display("FAIL oneshot_quiet got=%0d want=0", p);
    end
    sb.push_back(32'd0);
    bus(BASE + 32'h8, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL oneshot_cnt got=%h want=%h", r, e);
    end
  endtask

  task automatic test_w1c_race;
    logic [31:0] r, e;
    int n;
    int unsigned t;
    wr(5'h00, 32'd0, 4'hF);
    wr(5'h04, 32'd9, 4'hF);
    wr(5'h08, 32'd3, 4'hF);
    wr(5'h00, 32'd7, 4'hF);
    wait_irq(n);
    t = cyc;
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL race_first got=%0d want=4", n);
    end
    wr(5'h0C, 32'd1, 4'hF);
    while (cyc < t + 9) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL race_pre got=%b want=0", irq_out);
    end
    // This clear is accepted on the very edge of the next expiry.
    wr(5'h0C, 32'd1, 4'hF);
    checks++;
    if (irq_out !== 1'b1) begin
      failures++;
      $display("FAIL race_irq got=%b want=1", irq_out);
    end
    sb.push_back(32'd1);
    bus(BASE + 32'hC, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL race_exp got=%h want=%h", r, e);
    end
    wr(5'h00, 32'd0, 4'hF);
    wr(5'h0C, 32'd1, 4'hF);
    sb.push_back(32'd0);
    bus(BASE + 32'hC, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL w1c_clear got=%h want=%h", r, e);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r, e;
    int n, p;
    wr(5'h04, 32'h1234, 4'hF);
    wr(5'h08, 32'd1, 4'hF);
    wr(5'h00, 32'd7, 4'hF);
    wait_irq(n);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr = BASE + 32'h4;
    mem_wstrb = 4'd0;
    sb.push_back(32'h1234);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (mem_rdata !== e || mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got=%h want=%h", mem_rdata, e);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_ready, mem_rdata, irq_out} !== 34'd0) begin
      failures++;
      $display("FAIL mid_rst got=%h want=0",
               {mem_ready, mem_rdata, irq_out});
    end
    p = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (mem_ready) p++;
    end
    checks++;
    if (p !== 0) begin
      failures++;
      $display("FAIL mid_rdy got=%0d want=0", p);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(32'd0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (mem_ready !== 1'b1 || mem_rdata !== e) begin
      failures++;
      $display("FAIL mid_fresh got=%b/%h want=1/%h",
               mem_ready, mem_rdata, e);
    end
    mem_valid = 1'b0;
    sb.push_back(32'd0);
    bus(BASE + 32'h0, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL mid_ctrl got=%h want=%h", r, e);
    end
    sb.push_back(32'd0);
    bus(BASE + 32'h8, 32'd0, 4'd0, r, n);
    e = sb.pop_front();
    checks++;
    if (r !== e) begin
      failures++;
      $display("FAIL mid_cnt got=%h want=%h", r, e);
    end
  endtask

  initial begin
    test_reset;
    test_strobe;
    test_unmapped;
    test_back_to_back;
    test_auto_reload;
    test_one_shot;
    test_w1c_race;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
